// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the N-way round-robin arbiter.
// Holds the FSM encoding and the one-hot to index conversion.
package rr_arb_pkg;

    typedef enum logic {IDLE, BUSY} rr_state_t;

    localparam int IDX_W_MIN = 1;
    localparam int MAX_N     = 32;

    function automatic logic [4:0] onehot_to_idx(input logic [MAX_N-1:0] oh);
        logic [4:0] r;
        r = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (oh[i]) r = r | 5'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Wrap-around priority pick: first set bit of mask at or after start.
// Rotates the mask down by start, priority encodes, then rotates back.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     mask,
    input  logic [IDX_W-1:0] start,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [N-1:0]     rot;
    logic [IDX_W-1:0] off;
    logic [IDX_W:0]   sum;

    always_comb begin
        rot = N'({mask, mask} >> start);
        off = '0;
        // Descending scan so the lowest rotated bit wins.
        for (int j = N - 1; j >= 0; j--) begin
            if (rot[j]) off = IDX_W'(j);
        end
        sum = {1'b0, start} + {1'b0, off};
        if (sum >= (IDX_W + 1)'(N)) sum = sum - (IDX_W + 1)'(N);
        idx   = sum[IDX_W-1:0];
        found = |mask;
    end

endmodule

// File: rtl/round_robin_arbiter_n.sv
// N-requester round-robin arbiter with grant locking and bounded hold.
// Grants are registered; a holder is rotated out after MAX_HOLD cycles under contention.
module round_robin_arbiter_n
    import rr_arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 4,
    parameter int IDX_W    = (N > 1) ? $clog2(N) : IDX_W_MIN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     requests,
    output logic [N-1:0]     grants,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx
);

    localparam int HW = $clog2(MAX_HOLD + 1);

    rr_state_t        state_q, state_d;
    logic [N-1:0]     grants_q, grants_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;

    logic [N-1:0]     others;
    logic [N-1:0]     pick_mask;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic             release_g;
    logic             forced;
    logic             take;

    assign others    = requests & ~grants_q;
    assign release_g = ~|(requests & grants_q);
    assign forced    = (state_q == BUSY) && !release_g
                     && (hold_q >= HW'(MAX_HOLD)) && (|others);
    assign pick_mask = forced ? others : requests;

    rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .mask  (pick_mask),
        .start (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d  = state_q;
        grants_d = grants_q;
        hold_d   = hold_q;
        ptr_d    = ptr_q;
        take     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_found) take = 1'b1;
            end
            BUSY: begin
                if (release_g) begin
                    if (pick_found) begin
                        take = 1'b1;
                    end else begin
                        state_d  = IDLE;
                        grants_d = '0;
                        hold_d   = '0;
                    end
                end else if (forced) begin
                    take = 1'b1;
                end else if (hold_q < HW'(MAX_HOLD)) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (take) begin
            state_d  = BUSY;
            grants_d = N'(1) << pick_idx;
            hold_d   = HW'(1);
            ptr_d    = (pick_idx == IDX_W'(N - 1)) ? '0 : pick_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            grants_q <= '0;
            hold_q   <= '0;
            ptr_q    <= '0;
        end else begin
            state_q  <= state_d;
            grants_q <= grants_d;
            hold_q   <= hold_d;
            ptr_q    <= ptr_d;
        end
    end

    assign grants      = grants_q;
    assign grant_valid = |grants_q;
    assign grant_idx   = IDX_W'(onehot_to_idx(MAX_N'(grants_q)));

endmodule

// File: tb/tb_round_robin_arbiter_n.sv
// Self-checking bench for round_robin_arbiter_n with N=4, MAX_HOLD=3.
// Directed steps use an expectation queue; a random phase checks invariants.
module tb_round_robin_arbiter_n;

    localparam int N        = 4;
    localparam int MAX_HOLD = 3;
    localparam int BOUND    = (N - 1) * MAX_HOLD + 1;

    logic         clk;
    logic         rst;
    logic [N-1:0] requests;
    logic [N-1:0] grants;
    logic         grant_valid;
    logic [1:0]   grant_idx;

    int n_cmp;
    int n_err;

    logic [N-1:0] exp_q[$];
    string        tag_q[$];

    round_robin_arbiter_n #(
        .N        (N),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .requests    (requests),
        .grants      (grants),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] idx_of(input logic [N-1:0] oh);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            if (oh[i]) r = 4'(i);
        end
        return r;
    endfunction

    task automatic cmp(input string tag, input logic [3:0] got,
                       input logic [3:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic check_out();
        logic [N-1:0] e;
        string        t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        cmp({t, ".grants"}, 4'(grants), e);
        cmp({t, ".valid"}, 4'(grant_valid), 4'(|e));
        cmp({t, ".idx"}, 4'(grant_idx), idx_of(e));
    endtask

    task automatic expect_edge(input logic [N-1:0] e, input string t);
        exp_q.push_back(e);
        tag_q.push_back(t);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic drive(input logic [N-1:0] r, input logic [N-1:0] e,
                         input string t);
        @(negedge clk);
        requests = r;
        expect_edge(e, t);
    endtask

    logic [N-1:0] cont_seq[13];
    int           wait_cnt[N];
    logic [N-1:0] r;

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst      = 1'b1;
        requests = '0;

        #12;
        exp_q.push_back('0);
        tag_q.push_back("reset");
        check_out();
        @(negedge clk);
        rst = 1'b0;

        cont_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010,
                     4'b0100, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b1000,
                     4'b0001};
        for (int i = 0; i < 13; i++) drive(4'b1111, cont_seq[i], "contention");

        drive(4'b0011, 4'b0001, "early_hold");
        drive(4'b0010, 4'b0010, "early_release");

        drive(4'b1000, 4'b1000, "grant3");
        drive(4'b0000, 4'b0000, "release3");
        drive(4'b1001, 4'b0001, "wrap_ptr");
        for (int i = 0; i < 5; i++) drive(4'b0000, 4'b0000, "idle");
        drive(4'b0011, 4'b0010, "ptr_retained");

        for (int i = 0; i < 10; i++) drive(4'b0100, 4'b0100, "lone_holder");
        drive(4'b0101, 4'b0001, "forced_saturated");

        drive(4'b0001, 4'b0001, "pre_rst");
        rst = 1'b1;
        #2;
        exp_q.push_back('0);
        tag_q.push_back("async_rst");
        check_out();
        @(negedge clk);
        rst = 1'b0;
        expect_edge(4'b0001, "post_rst");
        drive(4'b0000, 4'b0000, "drain");

        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            r = requests;
            for (int i = 0; i < N; i++) begin
                if (!r[i]) begin
                    if ($urandom_range(2) == 0) r[i] = 1'b1;
                end else if (grants[i]) begin
                    if ($urandom_range(3) == 0) r[i] = 1'b0;
                end
            end
            requests = r;
            @(posedge clk);
            #1;
            cmp("rnd.onehot0", 4'($onehot0(grants)), 4'd1);
            cmp("rnd.valid", 4'(grant_valid), 4'(|grants));
            cmp("rnd.idx", 4'(grant_idx), idx_of(grants));
            cmp("rnd.granted_req", 4'(grants & ~requests), 4'b0000);
            for (int i = 0; i < N; i++) begin
                if (requests[i] && !grants[i]) wait_cnt[i]++;
                else wait_cnt[i] = 0;
            end
            for (int i = 0; i < N; i++) begin
                n_cmp++;
                assert (wait_cnt[i] <= BOUND) else begin
                    n_err++;
                    $error("FAIL rnd.starve%0d observed=%0d expected<=%0d",
                           i, wait_cnt[i], BOUND);
                    wait_cnt[i] = 0;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
